id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus operand forwarding for the RV32I core; drives A, B, ALU_control of the ALU.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/id_ex_stage_if.sv | 49 ++++
 rtl/fwd_unit.sv | 30 +++
 rtl/id_ex_stage.sv | 93 +++++++++
 tb/tb_id_ex_stage.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types for the RV32I core pipeline: widths, ALU op codes, forwarding selects
// and the ID/EX pipeline register layout.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SLT  = 4'b1001
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    // Everything the EX stage needs from decode, held across the ID/EX boundary.
    typedef struct packed {
        logic      valid;
        logic      reg_write;
        alu_op_t   alu_control;
        reg_addr_t rd_addr;
        reg_addr_t rs1_addr;
        reg_addr_t rs2_addr;
        logic      alu_src_a;
        logic      alu_src_b;
        word_t     pc;
        word_t     rs1_data;
        word_t     rs2_data;
        word_t     imm;
    } id_ex_t;

    // A later stage can supply a source only if it writes a real register (x0 is hardwired).
    function automatic logic fwd_hit(input logic we, input reg_addr_t rd, input reg_addr_t rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side bundle into the ID/EX stage: pipeline control, decoded operands,
// the two bypass ports, and the forwarding selects reported back for observation.
interface id_ex_stage_if;
    import core_pkg::*;

    logic       stall;
    logic       flush;
    logic       valid_in;
    word_t      pc_in;
    word_t      rs1_data_in;
    word_t      rs2_data_in;
    word_t      imm_in;
    reg_addr_t  rs1_addr_in;
    reg_addr_t  rs2_addr_in;
    reg_addr_t  rd_addr_in;
    logic [3:0] alu_control_in;
    logic       alu_src_a_in;
    logic       alu_src_b_in;
    logic       reg_write_in;

    logic       exmem_reg_write;
    reg_addr_t  exmem_rd;
    word_t      exmem_result;
    logic       memwb_reg_write;
    reg_addr_t  memwb_rd;
    word_t      memwb_result;

    fwd_sel_t   fwd_sel_rs1;
    fwd_sel_t   fwd_sel_rs2;

    modport master (
        output stall, flush, valid_in, pc_in, rs1_data_in, rs2_data_in, imm_in,
               rs1_addr_in, rs2_addr_in, rd_addr_in, alu_control_in,
               alu_src_a_in, alu_src_b_in, reg_write_in,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  fwd_sel_rs1, fwd_sel_rs2
    );

    modport slave (
        input  stall, flush, valid_in, pc_in, rs1_data_in, rs2_data_in, imm_in,
               rs1_addr_in, rs2_addr_in, rd_addr_in, alu_control_in,
               alu_src_a_in, alu_src_b_in, reg_write_in,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output fwd_sel_rs1, fwd_sel_rs2
    );

endinterface

// File: rtl/fwd_unit.sv
// Operand bypass for one source register: picks the youngest in-flight producer,
// EX/MEM before MEM/WB, otherwise the value read from the register file.
module fwd_unit
    import core_pkg::*;
(
    input  reg_addr_t rs_addr,
    input  word_t     reg_data,
    input  logic      exmem_reg_write,
    input  reg_addr_t exmem_rd,
    input  word_t     exmem_result,
    input  logic      memwb_reg_write,
    input  reg_addr_t memwb_rd,
    input  word_t     memwb_result,
    output fwd_sel_t  sel,
    output word_t     data
);

    always_comb begin
        sel  = FWD_REG;
        data = reg_data;
        if (fwd_hit(exmem_reg_write, exmem_rd, rs_addr)) begin
            sel  = FWD_EXMEM;
            data = exmem_result;
        end else if (fwd_hit(memwb_reg_write, memwb_rd, rs_addr)) begin
            sel  = FWD_MEMWB;
            data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush and EX/MEM, MEM/WB operand forwarding
// feeding the ALU operand muxes.
module id_ex_stage
    import core_pkg::*;
(
    input  logic                CLOCK,
    input  logic                RESET_N,
    id_ex_stage_if.slave        bus,
    output word_t               A,
    output word_t               B,
    output logic [3:0]          ALU_control,
    output word_t               store_data,
    output reg_addr_t           rd_addr_out,
    output logic                reg_write_out,
    output logic                valid_out
);

    id_ex_t ex_reg;
    id_ex_t ex_next;

    reg_addr_t src_addr [2];
    word_t     src_data [2];
    fwd_sel_t  fwd_sel  [2];
    word_t     fwd_data [2];

    // Bubble only needs its control fields zeroed; operand fields keep whatever they held.
    always_comb begin
        ex_next = ex_reg;
        if (bus.flush) begin
            ex_next.valid       = 1'b0;
            ex_next.reg_write   = 1'b0;
            ex_next.alu_control = ALU_ADD;
            ex_next.rd_addr     = '0;
        end else if (!bus.stall) begin
            ex_next.valid       = bus.valid_in;
            ex_next.reg_write   = bus.reg_write_in;
            ex_next.alu_control = alu_op_t'(bus.alu_control_in);
            ex_next.rd_addr     = bus.rd_addr_in;
            ex_next.rs1_addr    = bus.rs1_addr_in;
            ex_next.rs2_addr    = bus.rs2_addr_in;
            ex_next.alu_src_a   = bus.alu_src_a_in;
            ex_next.alu_src_b   = bus.alu_src_b_in;
            ex_next.pc          = bus.pc_in;
            ex_next.rs1_data    = bus.rs1_data_in;
            ex_next.rs2_data    = bus.rs2_data_in;
            ex_next.imm         = bus.imm_in;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_reg <= '0;
        end else begin
            ex_reg <= ex_next;
        end
    end

    assign src_addr[0] = ex_reg.rs1_addr;
    assign src_addr[1] = ex_reg.rs2_addr;
    assign src_data[0] = ex_reg.rs1_data;
    assign src_data[1] = ex_reg.rs2_data;

    // Bypass inputs are live, so a held (stalled) instruction still picks up new results.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit u_fwd (
                .rs_addr         (src_addr[gi]),
                .reg_data        (src_data[gi]),
                .exmem_reg_write (bus.exmem_reg_write),
                .exmem_rd        (bus.exmem_rd),
                .exmem_result    (bus.exmem_result),
                .memwb_reg_write (bus.memwb_reg_write),
                .memwb_rd        (bus.memwb_rd),
                .memwb_result    (bus.memwb_result),
                .sel             (fwd_sel[gi]),
                .data            (fwd_data[gi])
            );
        end
    endgenerate

    assign bus.fwd_sel_rs1 = fwd_sel[0];
    assign bus.fwd_sel_rs2 = fwd_sel[1];

    assign A             = ex_reg.alu_src_a ? ex_reg.pc  : fwd_data[0];
    assign B             = ex_reg.alu_src_b ? ex_reg.imm : fwd_data[1];
    assign store_data    = fwd_data[1];
    assign ALU_control   = ex_reg.alu_control;
    assign rd_addr_out   = ex_reg.rd_addr;
    assign reg_write_out = ex_reg.reg_write;
    assign valid_out     = ex_reg.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding priority, x0, flush, stall.
module tb_id_ex_stage;
    import core_pkg::*;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    word_t      A, B, store_data;
    logic [3:0] ALU_control;
    reg_addr_t  rd_addr_out;
    logic       reg_write_out, valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLOCK = ~CLOCK;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .CLOCK         (CLOCK),
        .RESET_N       (RESET_N),
        .bus           (bus),
        .A             (A),
        .B             (B),
        .ALU_control   (ALU_control),
        .store_data    (store_data),
        .rd_addr_out   (rd_addr_out),
        .reg_write_out (reg_write_out),
        .valid_out     (valid_out)
    );

    function automatic word_t alu_ref(input logic [3:0] op, input word_t a, input word_t b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return a << b[4:0];
            4'b0110: return a >> b[4:0];
            4'b0111: return word_t'($signed(a) >>> b[4:0]);
            4'b1000: return {31'd0, a < b};
            4'b1001: return {31'd0, $signed(a) < $signed(b)};
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clear_bypass;
        bus.exmem_reg_write = 1'b0; bus.exmem_rd = '0; bus.exmem_result = '0;
        bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0; bus.memwb_result = '0;
    endtask

    task automatic drive(input logic valid, input word_t pc, input reg_addr_t rs1a, input word_t rs1d,
                         input reg_addr_t rs2a, input word_t rs2d, input word_t imm, input reg_addr_t rd,
                         input logic [3:0] ctrl, input logic sa, input logic sb, input logic rw);
        bus.valid_in = valid;   bus.pc_in = pc;
        bus.rs1_addr_in = rs1a; bus.rs1_data_in = rs1d;
        bus.rs2_addr_in = rs2a; bus.rs2_data_in = rs2d;
        bus.imm_in = imm;       bus.rd_addr_in = rd;
        bus.alu_control_in = ctrl;
        bus.alu_src_a_in = sa;  bus.alu_src_b_in = sb;
        bus.reg_write_in = rw;
    endtask

    initial begin
        RESET_N = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clear_bypass();
        drive(1'b0, '0, '0, '0, '0, '0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        RESET_N = 1'b1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_A", A, 32'd0);

        // 1. Asynchronous reset in the middle of a cycle holding a valid ADD
        drive(1'b1, 32'h100, 5'd1, 32'h111, 5'd2, 32'h222, '0, 5'd3, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        $display("load ADD: A=0x%08h B=0x%08h valid=%0d", A, B, valid_out);
        chk("pre_rst_valid", 32'(valid_out), 32'd1);
        chk("pre_rst_A", A, 32'h111);
        #2 RESET_N = 1'b0;
        #1;
        $display("async reset mid-cycle: valid=%0d ctrl=%0h A=0x%08h", valid_out, ALU_control, A);
        chk("arst_valid", 32'(valid_out), 32'd0);
        chk("arst_rw", 32'(reg_write_out), 32'd0);
        chk("arst_ctrl", 32'(ALU_control), 32'd0);
        chk("arst_A", A, 32'd0);
        chk("arst_B", B, 32'd0);
        #1 RESET_N = 1'b1;

        // 2. Plain load, one-cycle latency
        drive(1'b1, 32'h200, 5'd1, 32'h10, 5'd2, 32'h20, '0, 5'd3, 4'b0001, 1'b0, 1'b0, 1'b1);
        chk("lat_A_before", A, 32'd0);
        tick();
        $display("load SUB: A=0x%08h B=0x%08h ctrl=%0h", A, B, ALU_control);
        chk("load_A", A, 32'h10);
        chk("load_B", B, 32'h20);
        chk("load_ctrl", 32'(ALU_control), 32'h1);
        chk("load_valid", 32'(valid_out), 32'd1);
        chk("load_rd", 32'(rd_addr_out), 32'd3);
        chk("load_alu", alu_ref(ALU_control, A, B), 32'hFFFF_FFF0);

        // 3. Both bypass stages target rs1; EX/MEM is younger and wins
        drive(1'b1, 32'h300, 5'd5, 32'h1234, 5'd6, 32'h66, '0, 5'd7, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'hAAAA;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'hBBBB;
        #1;
        $display("double hazard: A=0x%08h sel=%0d", A, bus.fwd_sel_rs1);
        chk("dbl_A", A, 32'hAAAA);
        chk("dbl_sel", 32'(bus.fwd_sel_rs1), 32'(FWD_EXMEM));
        bus.exmem_reg_write = 1'b0;
        #1;
        chk("memwb_A", A, 32'hBBBB);
        chk("memwb_sel", 32'(bus.fwd_sel_rs1), 32'(FWD_MEMWB));
        bus.memwb_rd = 5'd6;
        #1;
        chk("nofwd_A", A, 32'h1234);
        chk("memwb_B", B, 32'hBBBB);
        chk("memwb_store", store_data, 32'hBBBB);
        chk("fwd_alu", alu_ref(ALU_control, A, B), 32'h1234 + 32'hBBBB);
        clear_bypass();

        // 4. x0 is never forwarded
        drive(1'b1, 32'h400, 5'd1, 32'h5, 5'd0, 32'h0, '0, 5'd2, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hDEAD;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hBEEF;
        #1;
        $display("x0 source: B=0x%08h store=0x%08h", B, store_data);
        chk("x0_B", B, 32'd0);
        chk("x0_store", store_data, 32'd0);
        chk("x0_sel", 32'(bus.fwd_sel_rs2), 32'(FWD_REG));
        clear_bypass();

        // 5. Flush beats stall on the same edge
        drive(1'b1, 32'h500, 5'd1, 32'h1, 5'd2, 32'h2, '0, 5'd4, 4'b0100, 1'b0, 1'b0, 1'b1);
        tick();
        chk("preflush_valid", 32'(valid_out), 32'd1);
        bus.stall = 1'b1; bus.flush = 1'b1;
        drive(1'b1, 32'h510, 5'd3, 32'h3, 5'd4, 32'h4, '0, 5'd7, 4'b0001, 1'b0, 1'b0, 1'b1);
        tick();
        $display("stall+flush: valid=%0d rw=%0d ctrl=%0h rd=%0d", valid_out, reg_write_out, ALU_control, rd_addr_out);
        chk("flush_valid", 32'(valid_out), 32'd0);
        chk("flush_rw", 32'(reg_write_out), 32'd0);
        chk("flush_ctrl", 32'(ALU_control), 32'd0);
        chk("flush_rd", 32'(rd_addr_out), 32'd0);
        bus.stall = 1'b0; bus.flush = 1'b0;

        // 6. Immediate operand, then a 3-cycle stall under changing inputs
        drive(1'b1, 32'h400, 5'd7, 32'h70, 5'd8, 32'h80, 32'hFFFF_FFF0, 5'd9, 4'b1000, 1'b0, 1'b1, 1'b1);
        tick();
        $display("load SLTU imm: A=0x%08h B=0x%08h store=0x%08h", A, B, store_data);
        chk("imm_B", B, 32'hFFFF_FFF0);
        chk("imm_store", store_data, 32'h80);
        chk("imm_alu", alu_ref(ALU_control, A, B), 32'd1);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h900 + 32'(i), 5'd10 + 5'(i), 32'h1000 + 32'(i), 5'd20 + 5'(i),
                  32'h2000 + 32'(i), 32'h3000 + 32'(i), 5'd30, 4'b0100, 1'b1, 1'b0, 1'b0);
            tick();
            $display("stall cycle %0d: A=0x%08h B=0x%08h valid=%0d", i, A, B, valid_out);
            chk("stall_A", A, 32'h70);
            chk("stall_B", B, 32'hFFFF_FFF0);
            chk("stall_ctrl", 32'(ALU_control), 32'h8);
            chk("stall_rd", 32'(rd_addr_out), 32'd9);
            chk("stall_valid", 32'(valid_out), 32'd1);
        end
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'h5555;
        #1;
        chk("stall_fwd_store", store_data, 32'h5555);
        chk("stall_fwd_B", B, 32'hFFFF_FFF0);

        // Release the stall: PC operand with a forwarded rs2
        bus.stall = 1'b0;
        drive(1'b1, 32'h800, 5'd1, 32'h11, 5'd8, 32'h88, '0, 5'd12, 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        $display("release: A=0x%08h B=0x%08h rd=%0d", A, B, rd_addr_out);
        chk("rel_A", A, 32'h800);
        chk("rel_B", B, 32'h5555);
        chk("rel_alu", alu_ref(ALU_control, A, B), 32'h5D55);

        // Reset while stalled
        bus.stall = 1'b1;
        #2 RESET_N = 1'b0;
        #1;
        $display("reset during stall: valid=%0d A=0x%08h B=0x%08h", valid_out, A, B);
        chk("stall_rst_valid", 32'(valid_out), 32'd0);
        chk("stall_rst_A", A, 32'd0);
        chk("stall_rst_B", B, 32'd0);
        #1 RESET_N = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
